// File: rtl/adi2axis_capture_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : adi2axis_pkg
// Desc   : State encoding, capture modes and status-word layout for the
//          ADC-to-AXIS capture sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package adi2axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_HOLDOFF   = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [1:0] MODE_IMM   = 2'd0;
  localparam logic [1:0] MODE_EDGE  = 2'd1;
  localparam logic [1:0] MODE_GATED = 2'd2;

  localparam int c_stat_busy     = 0;
  localparam int c_stat_done     = 1;
  localparam int c_stat_abort    = 2;
  localparam int c_stat_wait     = 3;
  localparam int c_stat_state_lo = 4;
  localparam int c_stat_burst_lo = 16;

  // The reserved mode code behaves exactly like immediate capture.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'd3) ? MODE_IMM : mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adi2axis_capture_seq_if.sv
`default_nettype none
// ============================================================================
// Module : adi2axis_capture_seq_if
// Desc   : Sample-strobe / TREADY in, capture-enable / TLAST qualifier out.
// Rev    : 1.0 - initial release
// ============================================================================
interface adi2axis_capture_seq_if;
  logic smp_valid;
  logic s_ready;
  logic capture_en;
  logic beat_last;

  modport master (
    input  smp_valid,
    input  s_ready,
    output capture_en,
    output beat_last
  );

  modport slave (
    output smp_valid,
    output s_ready,
    input  capture_en,
    input  beat_last
  );
endinterface
`default_nettype wire

// File: rtl/adi2axis_capture_seq_trig_qual.sv
`default_nettype none
// ============================================================================
// Module : adi2axis_trig_qual
// Desc   : Trigger history register plus edge/level qualification.
// Rev    : 1.0 - initial release
// ============================================================================
module adi2axis_trig_qual
  import adi2axis_pkg::*;
(
  input  wire       AXIS_ACLK,
  input  wire       AXIS_RESET,
  input  wire       trig,
  input  wire [1:0] mode,
  output logic      trig_fire,
  output logic      trig_gate
);

  logic r_trig_d;

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_RESET) begin
      r_trig_d <= 1'b0;
    end else begin
      r_trig_d <= trig;
    end
  end

  // Gate stays open outside gated mode so capture is decided by state alone.
  always_comb begin
    trig_fire = 1'b0;
    trig_gate = 1'b1;
    case (mode)
      MODE_EDGE:  trig_fire = trig & ~r_trig_d;
      MODE_GATED: begin
        trig_fire = trig;
        trig_gate = trig;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/adi2axis_capture_seq.sv
`default_nettype none
// ============================================================================
// Module : adi2axis_capture_seq
// Desc   : Multi-burst capture sequencer gating converter samples onto AXIS.
// Rev    : 1.0 - initial release
// ============================================================================
module adi2axis_capture_seq
  import adi2axis_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  wire                    AXIS_ACLK,
  input  wire                    AXIS_RESET,
  input  wire                    cmd_start,
  input  wire                    cmd_abort,
  input  wire [1:0]              cfg_mode,
  input  wire [CNT_W-1:0]        cfg_num_beats,
  input  wire [BURST_W-1:0]      cfg_num_bursts,
  input  wire [BURST_W-1:0]      cfg_holdoff,
  input  wire                    trig,
  adi2axis_capture_seq_if.master axis,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            ovf_cnt,
  output logic [31:0]            stat
);

  localparam logic [CNT_W-1:0]   c_beat_one  = CNT_W'(1);
  localparam logic [BURST_W-1:0] c_burst_one = BURST_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_mode;
  logic [CNT_W-1:0]   r_beats;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [BURST_W-1:0] r_bursts;
  logic [BURST_W-1:0] r_holdoff;
  logic [BURST_W-1:0] r_burst_cnt;
  logic [BURST_W-1:0] r_hold_cnt;
  logic [15:0]        r_ovf_cnt;
  logic               r_done_sticky;
  logic               r_abort_sticky;

  logic w_trig_fire;
  logic w_trig_gate;
  logic w_cap_en;
  logic w_last;
  logic w_xfr;
  logic w_drop;
  logic w_burst_end;
  logic w_final;
  logic w_hold_end;
  logic w_start;
  logic w_abort;

  adi2axis_trig_qual u_trig_qual (
    .AXIS_ACLK  (AXIS_ACLK),
    .AXIS_RESET (AXIS_RESET),
    .trig       (trig),
    .mode       (r_mode),
    .trig_fire  (w_trig_fire),
    .trig_gate  (w_trig_gate)
  );

  assign w_cap_en    = (r_state == ST_CAPTURE) & w_trig_gate;
  assign w_last      = w_cap_en & (r_beat_cnt == r_beats - c_beat_one);
  assign w_xfr       = w_cap_en & axis.smp_valid & axis.s_ready;
  assign w_drop      = w_cap_en & axis.smp_valid & ~axis.s_ready;
  assign w_burst_end = w_xfr & w_last;
  assign w_final     = (r_burst_cnt == r_bursts - c_burst_one);
  assign w_hold_end  = (r_hold_cnt == r_holdoff - c_burst_one);
  assign w_start     = cmd_start & (r_state == ST_IDLE);
  assign w_abort     = cmd_abort & (r_state != ST_IDLE);

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort overrides every transition, including a simultaneous final beat.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (cmd_start) w_next = ST_ARM;
      ST_ARM:       w_next = (r_mode == MODE_IMM) ? ST_CAPTURE : ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (w_trig_fire) w_next = ST_CAPTURE;
      ST_CAPTURE:   if (w_burst_end) w_next = w_final ? ST_DONE : ST_HOLDOFF;
      ST_HOLDOFF:   if (w_hold_end) w_next = (r_mode == MODE_IMM) ? ST_CAPTURE : ST_WAIT_TRIG;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_RESET) begin
      r_mode         <= MODE_IMM;
      r_beats        <= '0;
      r_bursts       <= '0;
      r_holdoff      <= '0;
      r_beat_cnt     <= '0;
      r_burst_cnt    <= '0;
      r_hold_cnt     <= '0;
      r_ovf_cnt      <= '0;
      r_done_sticky  <= 1'b0;
      r_abort_sticky <= 1'b0;
    end else begin
      if (w_start) begin
        r_mode         <= norm_mode(cfg_mode);
        r_beats        <= (cfg_num_beats == '0) ? c_beat_one : cfg_num_beats;
        r_bursts       <= (cfg_num_bursts == '0) ? c_burst_one : cfg_num_bursts;
        r_holdoff      <= (cfg_holdoff == '0) ? c_burst_one : cfg_holdoff;
        r_beat_cnt     <= '0;
        r_burst_cnt    <= '0;
        r_ovf_cnt      <= '0;
        r_done_sticky  <= 1'b0;
        r_abort_sticky <= 1'b0;
      end else begin
        if (w_xfr) begin
          r_beat_cnt <= w_last ? '0 : r_beat_cnt + c_beat_one;
        end
        if (w_burst_end && !w_final) begin
          r_burst_cnt <= r_burst_cnt + c_burst_one;
        end
        if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
          r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
        if (r_state == ST_DONE) begin
          r_done_sticky <= 1'b1;
        end
        if (w_abort) begin
          r_abort_sticky <= 1'b1;
        end
      end
      r_hold_cnt <= (r_state == ST_HOLDOFF) ? r_hold_cnt + c_burst_one : '0;
    end
  end

  assign axis.capture_en = w_cap_en;
  assign axis.beat_last  = w_last;
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE);
  assign ovf_cnt         = r_ovf_cnt;

  always_comb begin
    stat                          = '0;
    stat[c_stat_busy]             = busy;
    stat[c_stat_done]             = r_done_sticky;
    stat[c_stat_abort]            = r_abort_sticky;
    stat[c_stat_wait]             = (r_state == ST_WAIT_TRIG);
    stat[c_stat_state_lo +: 3]    = r_state;
    stat[c_stat_burst_lo +: 16]   = 16'(r_burst_cnt);
  end

endmodule
`default_nettype wire

// File: tb/tb_adi2axis_capture_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_adi2axis_capture_seq
// Desc   : Scoreboard bench: expected beats queued at start, popped per transfer.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_adi2axis_capture_seq;
  import adi2axis_pkg::*;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  typedef struct {
    logic        last;
    logic [15:0] burst;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_start = 1'b0;
  logic               cmd_abort = 1'b0;
  logic               trig = 1'b0;
  logic [1:0]         cfg_mode = 2'd0;
  logic [CNT_W-1:0]   cfg_num_beats = '0;
  logic [BURST_W-1:0] cfg_num_bursts = '0;
  logic [BURST_W-1:0] cfg_holdoff = '0;
  logic               busy;
  logic               done;
  logic [15:0]        ovf_cnt;
  logic [31:0]        stat;

  adi2axis_capture_seq_if bus();

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_xfr = 0;
  int n_last = 0;
  int n_done = 0;
  int last_xfr_cyc = -100;
  int first_cap_cyc = -1;
  int start_cyc = 0;
  int trig_cyc = 0;
  int b_x, b_l, b_d;

  adi2axis_capture_seq #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_RESET     (rst),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .cfg_mode       (cfg_mode),
    .cfg_num_beats  (cfg_num_beats),
    .cfg_num_bursts (cfg_num_bursts),
    .cfg_holdoff    (cfg_holdoff),
    .trig           (trig),
    .axis           (bus),
    .busy           (busy),
    .done           (done),
    .ovf_cnt        (ovf_cnt),
    .stat           (stat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Transfer monitor: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.capture_en && first_cap_cyc < 0) first_cap_cyc = cyc;
      if (bus.capture_en && bus.beat_last) n_last++;
      if (bus.capture_en && bus.smp_valid && bus.s_ready) begin
        n_xfr++;
        check_val("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_val("beat_last", bus.beat_last, e.last);
          check_val("burst_idx", stat[31:16], e.burst);
        end
        last_xfr_cyc = cyc;
      end
      if (done) begin
        n_done++;
        check_val("done_after_last", cyc, last_xfr_cyc + 1);
        check_val("done_cap_off", bus.capture_en, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int beats, input int bursts);
    int eb;
    int ebr;
    eb  = (beats == 0) ? 1 : beats;
    ebr = (bursts == 0) ? 1 : bursts;
    for (int b = 0; b < ebr; b++) begin
      for (int i = 0; i < eb; i++) begin
        exp_t e;
        e.last  = (i == eb - 1);
        e.burst = 16'(b);
        sb.push_back(e);
      end
    end
  endtask

  task automatic start_cap(input logic [1:0] mode, input int beats, input int bursts, input int hold);
    cfg_mode       = mode;
    cfg_num_beats  = CNT_W'(beats);
    cfg_num_bursts = BURST_W'(bursts);
    cfg_holdoff    = BURST_W'(hold);
    push_exp(beats, bursts);
    first_cap_cyc  = -1;
    b_x = n_xfr; b_l = n_last; b_d = n_done;
    cmd_start = 1'b1;
    start_cyc = cyc;
    step();
    cmd_start = 1'b0;
    cfg_num_beats  = CNT_W'($urandom_range(2, 50));
    cfg_num_bursts = BURST_W'($urandom_range(2, 9));
    cfg_holdoff    = BURST_W'($urandom_range(0, 9));
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 300) begin
      step();
      k++;
    end
    check_val(tag, busy, 0);
  endtask

  task automatic wait_xfr(input int target, input string tag);
    int k;
    k = 0;
    while (n_xfr < target && k < 100) begin
      step();
      k++;
    end
    check_val(tag, n_xfr >= target, 1);
  endtask

  task automatic wait_trig_state(input string tag);
    int k;
    k = 0;
    while (!stat[3] && k < 100) begin
      step();
      k++;
    end
    check_val(tag, stat[3], 1);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    trig_cyc = cyc;
    first_cap_cyc = -1;
    step();
    trig = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.smp_valid = 1'b1;
    bus.s_ready   = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_val("rst_capture_en", bus.capture_en, 0);
    check_val("rst_beat_last", bus.beat_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_ovf", ovf_cnt, 0);
    check_val("rst_stat", stat, 0);
    step();
    rst = 1'b0;
    step();

    // Immediate mode, single 4-beat burst.
    start_cap(MODE_IMM, 4, 1, 0);
    check_val("t1_arm", stat[6:4], ST_ARM);
    wait_idle("t1_idle");
    check_val("t1_xfr", n_xfr - b_x, 4);
    check_val("t1_last", n_last - b_l, 1);
    check_val("t1_done", n_done - b_d, 1);
    check_val("t1_first_cap", first_cap_cyc, start_cyc + 2);
    check_val("t1_done_sticky", stat[1], 1);
    check_val("t1_sb_drained", sb.size(), 0);

    // Edge-triggered, two 3-beat bursts with holdoff 5.
    start_cap(MODE_EDGE, 3, 2, 5);
    wait_trig_state("t2_wait1");
    step(); step();
    check_val("t2_no_cap_before_trig", first_cap_cyc, -1);
    pulse_trig();
    wait_trig_state("t2_wait2");
    check_val("t2_holdoff_len", cyc, last_xfr_cyc + 6);
    check_val("t2_cap_after_edge1", first_cap_cyc, trig_cyc + 1);
    check_val("t2_burst_idx_hold", stat[31:16], 1);
    step();
    pulse_trig();
    wait_idle("t2_idle");
    check_val("t2_cap_after_edge2", first_cap_cyc, trig_cyc + 1);
    check_val("t2_xfr", n_xfr - b_x, 6);
    check_val("t2_last", n_last - b_l, 2);
    check_val("t2_done", n_done - b_d, 1);
    check_val("t2_sb_drained", sb.size(), 0);

    // Level-gated, 6 beats with a 2-cycle trigger dropout mid-burst.
    trig = 1'b1;
    start_cap(MODE_GATED, 6, 1, 0);
    wait_xfr(b_x + 2, "t3_reach2");
    trig = 1'b0;
    @(negedge clk);
    check_val("t3_gate_low0", bus.capture_en, 0);
    step();
    @(negedge clk);
    check_val("t3_gate_low1", bus.capture_en, 0);
    check_val("t3_still_capture", stat[6:4], ST_CAPTURE);
    step();
    trig = 1'b1;
    wait_idle("t3_idle");
    trig = 1'b0;
    check_val("t3_xfr", n_xfr - b_x, 6);
    check_val("t3_last", n_last - b_l, 1);
    check_val("t3_done", n_done - b_d, 1);

    // Backpressure: 3 dropped samples, then saturation.
    start_cap(MODE_IMM, 4, 1, 0);
    wait_xfr(b_x + 1, "t4_reach1");
    bus.s_ready = 1'b0;
    repeat (3) step();
    bus.s_ready = 1'b1;
    wait_idle("t4_idle");
    check_val("t4_ovf", ovf_cnt, 3);
    check_val("t4_xfr", n_xfr - b_x, 4);
    check_val("t4_last", n_last - b_l, 1);
    start_cap(MODE_IMM, 1, 1, 0);
    check_val("t4b_ovf_cleared", ovf_cnt, 0);
    bus.s_ready = 1'b0;
    repeat (70000) step();
    check_val("t4b_ovf_sat", ovf_cnt, 16'hFFFF);
    check_val("t4b_busy", busy, 1);
    bus.s_ready = 1'b1;
    wait_idle("t4b_idle");
    check_val("t4b_ovf_hold", ovf_cnt, 16'hFFFF);
    check_val("t4b_xfr", n_xfr - b_x, 1);

    // Abort during beat 2 of 8, then a clean restart.
    start_cap(MODE_IMM, 8, 1, 0);
    wait_xfr(b_x + 1, "t5_reach1");
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    check_val("t5_cap_off", bus.capture_en, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_abort_sticky", stat[2], 1);
    check_val("t5_done_sticky", stat[1], 0);
    repeat (3) step();
    check_val("t5_xfr", n_xfr - b_x, 2);
    check_val("t5_no_last", n_last - b_l, 0);
    check_val("t5_no_done", n_done - b_d, 0);
    sb.delete();
    start_cap(MODE_IMM, 2, 1, 0);
    check_val("t5_abort_cleared", stat[2], 0);
    wait_idle("t5_restart_idle");
    check_val("t5_restart_xfr", n_xfr - b_x, 2);
    check_val("t5_restart_done", stat[1], 1);

    // Zero beats/bursts behave as 1/1; start while busy is ignored.
    bus.s_ready = 1'b0;
    start_cap(MODE_IMM, 0, 0, 0);
    step(); step();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    check_val("t6_start_ignored", stat[6:4], ST_CAPTURE);
    check_val("t6_last_first_beat", bus.beat_last, 1);
    bus.s_ready = 1'b1;
    wait_idle("t6_idle");
    check_val("t6_xfr", n_xfr - b_x, 1);
    check_val("t6_done", n_done - b_d, 1);
    check_val("t6_sb_drained", sb.size(), 0);

    // Reset in the middle of a capture.
    start_cap(MODE_IMM, 8, 2, 0);
    wait_xfr(b_x + 3, "t7_reach3");
    rst = 1'b1;
    step();
    check_val("t7_busy", busy, 0);
    check_val("t7_stat", stat, 0);
    check_val("t7_cap", bus.capture_en, 0);
    check_val("t7_ovf", ovf_cnt, 0);
    rst = 1'b0;
    sb.delete();
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
